l2_msg_out_arb: RTL and testbench

- Parametrised successor to the single L2 outbound message channels: a multi-channel buffered arbiter.
- Accepts packed L2 outbound coherence messages (req_out / rsp_out style payloads) from NUM_CH producer channels.
- Buffers each channel in its own FIFO.
- Merges all channels onto one valid/ready output toward the NoC/LLC.
- Supports selectable arbitration mode, grant locking and per-channel occupancy reporting.

---
 rtl/l2_msg_out_arb.sv | 141 ++++++++++++++
 tb/tb_l2_msg_out_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_msg_out_arb.sv
// l2_msg_out_arb: multi-channel buffered arbiter for L2 outbound coherence
// messages. Each producer channel feeds its own FIFO. A round-robin or
// fixed-priority arbiter merges the FIFO heads onto one valid/ready output.
// A grant is locked while the downstream stalls, so the presented message
// cannot change until it is accepted.
module l2_msg_out_arb #(
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 4,
  parameter int MSG_W     = 64,
  parameter int PRIO_MODE = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*MSG_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MSG_W-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic [NUM_CH*CNT_W-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MSG_W-1:0] mem_r    [NUM_CH][DEPTH];
  logic [PTR_W-1:0] wr_ptr_r [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_r [NUM_CH];
  logic [CNT_W-1:0] count_r  [NUM_CH];
  logic [CH_W-1:0]  rr_ptr_r;
  logic [CH_W-1:0]  locked_ch_r;
  logic [CH_W-1:0]  last_ch_r;
  logic             lock_r;

  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [CH_W-1:0]   gnt_s;
  logic              any_req_s;
  logic              found_s;
  int                idx_s;

  // Per-channel status: requests, back-pressure, handshakes and occupancy.
  always_comb begin
    req_s     = '0;
    push_s    = '0;
    pop_s     = '0;
    in_ready  = '0;
    occupancy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_s[i]    = (count_r[i] != CNT_W'(0));
      in_ready[i] = (count_r[i] != CNT_W'(DEPTH));
      push_s[i]   = in_valid[i] & in_ready[i];
      pop_s[i]    = out_valid & out_ready & (out_ch == CH_W'(i));
      occupancy[i*CNT_W +: CNT_W] = count_r[i];
    end
  end

  // Grant selection from registered state; a held lock overrides arbitration.
  always_comb begin
    gnt_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    if (PRIO_MODE == 1) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        gnt_s = req_s[k] ? CH_W'(k) : gnt_s;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx_s = int'(rr_ptr_r) + k;
        idx_s = (idx_s >= NUM_CH) ? (idx_s - NUM_CH) : idx_s;
        gnt_s   = (req_s[idx_s] && !found_s) ? CH_W'(idx_s) : gnt_s;
        found_s = found_s | req_s[idx_s];
      end
    end
    any_req_s = |req_s;
    out_valid = lock_r | any_req_s;
    if (lock_r) begin
      out_ch = locked_ch_r;
    end else if (any_req_s) begin
      out_ch = gnt_s;
    end else begin
      out_ch = last_ch_r;
    end
    out_data = out_valid ? mem_r[out_ch][rd_ptr_r[out_ch]] : '0;
  end

  // FIFO pointers and entry counts; pointers wrap at DEPTH-1 for any DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        count_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= (wr_ptr_r[i] == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= (rd_ptr_r[i] == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Message storage; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= in_data[i*MSG_W +: MSG_W];
      end
    end
  end

  // Arbiter state: grant lock under back-pressure, last grant, rr pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_r      <= 1'b0;
      locked_ch_r <= '0;
      last_ch_r   <= '0;
      rr_ptr_r    <= '0;
    end else begin
      lock_r      <= out_valid & ~out_ready;
      locked_ch_r <= out_ch;
      last_ch_r   <= out_ch;
      if ((PRIO_MODE == 0) && out_valid && out_ready) begin
        rr_ptr_r <= (out_ch == CH_W'(NUM_CH - 1)) ? CH_W'(0) : out_ch + CH_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_l2_msg_out_arb.sv
// Directed bench for l2_msg_out_arb. Three instances share the input
// stimulus: round-robin DEPTH=4, fixed-priority DEPTH=4 and round-robin
// DEPTH=3. Each check looks only at the instance the scenario targets.
module tb_l2_msg_out_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic [1:0] rr_in_ready, fp_in_ready, d3_in_ready;
  logic       rr_out_valid, fp_out_valid, d3_out_valid;
  logic [7:0] rr_out_data, fp_out_data, d3_out_data;
  logic       rr_out_ch, fp_out_ch, d3_out_ch;
  logic [5:0] rr_occ, fp_occ;
  logic [3:0] d3_occ;

  int total;
  int bad;

  typedef struct {
    logic       out_ready;
    logic       vld;
    logic       rr_ch;
    logic [7:0] rr_data;
    logic       fp_ch;
    logic [7:0] fp_data;
  } vec_t;

  vec_t tbl [9];

  l2_msg_out_arb #(.NUM_CH(2), .DEPTH(4), .MSG_W(8), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready),
    .in_data(in_data), .out_valid(rr_out_valid), .out_ready(out_ready),
    .out_data(rr_out_data), .out_ch(rr_out_ch), .occupancy(rr_occ));

  l2_msg_out_arb #(.NUM_CH(2), .DEPTH(4), .MSG_W(8), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fp_in_ready),
    .in_data(in_data), .out_valid(fp_out_valid), .out_ready(out_ready),
    .out_data(fp_out_data), .out_ch(fp_out_ch), .occupancy(fp_occ));

  l2_msg_out_arb #(.NUM_CH(2), .DEPTH(3), .MSG_W(8), .PRIO_MODE(0)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d3_in_ready),
    .in_data(in_data), .out_valid(d3_out_valid), .out_ready(out_ready),
    .out_data(d3_out_data), .out_ch(d3_out_ch), .occupancy(d3_occ));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 2'b00;
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic acc;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 2'b00;
    in_data   = 16'h0000;
    out_ready = 1'b0;

    // Expected drain order from a 4+4 preload with out_ready held high.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 8'h10};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 8'h11};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 8'h12};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h21, 1'b0, 8'h13};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 8'h20};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 8'h21};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h13, 1'b1, 8'h22};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h23, 1'b1, 8'h23};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};

    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state
    chk("rst_occ", 32'(rr_occ), 32'h0);
    chk("rst_in_ready", 32'(rr_in_ready), 32'h3);
    chk("rst_out_valid", 32'(rr_out_valid), 32'h0);
    chk("rst_out_ch", 32'(rr_out_ch), 32'h0);
    chk("rst_out_data", 32'(rr_out_data), 32'h0);

    // Reset mid-traffic
    in_valid = 2'b01;
    for (int n = 1; n <= 3; n++) begin
      in_data = {8'h00, 8'(n)};
      tick();
    end
    in_valid = 2'b00;
    chk("mid_occ_before", 32'(rr_occ[2:0]), 32'h3);
    rst = 1'b0;
    #1;
    chk("mid_occ_async", 32'(rr_occ), 32'h0);
    chk("mid_valid_async", 32'(rr_out_valid), 32'h0);
    chk("mid_ready_async", 32'(rr_in_ready), 32'h3);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 2'b01;
    in_data  = 16'h0077;
    chk("post_rst_ready", 32'(rr_in_ready[0]), 32'h1);
    tick();
    in_valid = 2'b00;
    chk("post_rst_occ", 32'(rr_occ[2:0]), 32'h1);
    chk("post_rst_data", 32'(rr_out_data), 32'h77);
    out_ready = 1'b1;
    tick();
    chk("post_rst_drain", 32'(rr_occ), 32'h0);

    // Fill to full on ch1, then drain in order while the held 5th enters
    do_reset();
    in_valid = 2'b10;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("fill_ready%0d", n), 32'(rr_in_ready[1]), (n < 4) ? 32'h1 : 32'h0);
      in_data = {8'(8'hA0 + n), 8'h00};
      if (n < 4) tick();
    end
    chk("full_occ1", 32'(rr_occ[5:3]), 32'h4);
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("drain_valid%0d", n), 32'(rr_out_valid), 32'h1);
      chk($sformatf("drain_ch%0d", n), 32'(rr_out_ch), 32'h1);
      chk($sformatf("drain_data%0d", n), 32'(rr_out_data), 32'(8'hA0 + n));
      acc = in_valid[1] & rr_in_ready[1];
      tick();
      if (acc) in_valid = 2'b00;
    end
    chk("drain_empty", 32'(rr_out_valid), 32'h0);
    chk("drain_occ", 32'(rr_occ), 32'h0);

    // Round-robin vs fixed priority, table-driven
    do_reset();
    in_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      in_data = {8'(8'h20 + n), 8'(8'h10 + n)};
      tick();
    end
    in_valid = 2'b00;
    for (int r = 0; r < 9; r++) begin
      out_ready = tbl[r].out_ready;
      chk($sformatf("rr_valid%0d", r), 32'(rr_out_valid), 32'(tbl[r].vld));
      chk($sformatf("rr_ch%0d", r), 32'(rr_out_ch), 32'(tbl[r].rr_ch));
      chk($sformatf("rr_data%0d", r), 32'(rr_out_data), 32'(tbl[r].rr_data));
      chk($sformatf("fp_valid%0d", r), 32'(fp_out_valid), 32'(tbl[r].vld));
      chk($sformatf("fp_ch%0d", r), 32'(fp_out_ch), 32'(tbl[r].fp_ch));
      chk($sformatf("fp_data%0d", r), 32'(fp_out_data), 32'(tbl[r].fp_data));
      tick();
    end

    // Grant lock under backpressure (fixed priority)
    do_reset();
    in_valid = 2'b10;
    in_data  = 16'h5500;
    tick();
    chk("lock_c0_ch", 32'(fp_out_ch), 32'h1);
    chk("lock_c0_data", 32'(fp_out_data), 32'h55);
    in_valid = 2'b01;
    in_data  = 16'h0066;
    tick();
    in_valid = 2'b00;
    chk("lock_c1_ch", 32'(fp_out_ch), 32'h1);
    chk("lock_c1_data", 32'(fp_out_data), 32'h55);
    tick();
    chk("lock_c2_ch", 32'(fp_out_ch), 32'h1);
    chk("lock_c2_data", 32'(fp_out_data), 32'h55);
    chk("lock_c2_occ0", 32'(fp_occ[2:0]), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("lock_after_ch", 32'(fp_out_ch), 32'h0);
    chk("lock_after_data", 32'(fp_out_data), 32'h66);
    tick();
    chk("lock_after_empty", 32'(fp_out_valid), 32'h0);

    // Concurrent push/pop with pointer wrap at DEPTH=3
    do_reset();
    out_ready = 1'b1;
    in_valid  = 2'b01;
    in_data   = 16'h00C0;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("d3_occ%0d", k), 32'(d3_occ[1:0]), 32'h1);
      chk($sformatf("d3_data%0d", k), 32'(d3_out_data), 32'(8'hC0 + k));
      chk($sformatf("d3_ch%0d", k), 32'(d3_out_ch), 32'h0);
      if (k < 9) in_data = {8'h00, 8'(8'hC1 + k)};
      else       in_valid = 2'b00;
      tick();
    end
    chk("d3_end_occ", 32'(d3_occ), 32'h0);
    chk("d3_end_valid", 32'(d3_out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
